// File: rtl/stack_pkg.sv
// Shared definitions for the stack host controller.
// Contents: FSM state encoding, response error codes, parameter defaults and
// the timer-width helper used by the controller and its wait timer.
package stack_pkg;

    localparam int DEPTH_DEF       = 128;
    localparam int STROBE_CYC_DEF  = 2;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUSH_DRV  = 3'd1,
        ST_PUSH_WAIT = 3'd2,
        ST_POP_STB   = 3'd3,
        ST_POP_WAIT  = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_FULL    = 2'd1,
        ERR_EMPTY   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    // The timer must be able to hold the full timeout value itself.
    function automatic int timer_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/stack_wait_timer.sv
// Down-counting wait timer shared by the strobe-length and timeout counts.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load       load load_val (has priority over counting)
//   load_val   start value; the timer expires load_val+1 enabled cycles later
//   en         count enable
//   expire     high in an enabled cycle in which the count has reached zero
module stack_wait_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Not gated by load: the controller reloads in the same cycle the
    // strobe count expires, and gating would create a combinational loop.
    assign expire = en && (count == '0);

endmodule

// File: rtl/stack_host_ctrl.sv
// Host-side controller for the pin-level push/pop stack device.
// Accepts push/pop commands on a ready/valid port, drives the device strobes
// and data bus, keeps a shadow occupancy count and returns pop data or an
// error code on a one-cycle response pulse.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/ready/pop/data   command port (pop=1 pop, pop=0 push)
//   rsp_valid/data/err         response pulse, popped byte, error code
//   stk_push/pop/dout/doe      strobes and driven bus toward the device
//   stk_din/done/empty/full    bus read data and status from the device
//   occupancy                  shadow entry count
//   desync                     sticky shadow-vs-device flag mismatch
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a command; flags compared against shadow count
// PUSH_DRV  | bus driven, push strobe held for STROBE_CYC cycles
// PUSH_WAIT | bus still driven, waiting for done or timeout
// POP_STB   | bus released, pop strobe held for STROBE_CYC cycles
// POP_WAIT  | waiting for done (data captured then) or timeout
// RESP      | one-cycle response pulse
module stack_host_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int STROBE_CYC  = STROBE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_pop,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_err,
    output logic       stk_push,
    output logic       stk_pop,
    output logic [7:0] stk_dout,
    output logic       stk_doe,
    input  logic [7:0] stk_din,
    input  logic       stk_done,
    input  logic       stk_empty,
    input  logic       stk_full,
    output logic [7:0] occupancy,
    output logic       desync
);

    localparam int TW = timer_width(TIMEOUT_CYC);
    localparam logic [TW-1:0] STB_LOAD = TW'(STROBE_CYC - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC);
    localparam logic [7:0]    DEPTH_V  = 8'(DEPTH);

    state_t      state, state_next;
    err_t        err_q, err_next;
    logic [7:0]  push_data_q;
    logic [7:0]  rsp_data_q;
    logic [7:0]  occ_q;
    logic        desync_q;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_expire;

    logic accept;
    logic occ_inc;
    logic occ_dec;
    logic capture;
    logic occ_zero;
    logic occ_full;

    assign occ_zero = (occ_q == 8'd0);
    assign occ_full = (occ_q == DEPTH_V);

    stack_wait_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = err_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;
        accept     = 1'b0;
        occ_inc    = 1'b0;
        occ_dec    = 1'b0;
        capture    = 1'b0;
        cmd_ready  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_doe    = 1'b0;
        rsp_valid  = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (!cmd_pop) begin
                        if (occ_full || stk_full) begin
                            err_next   = ERR_FULL;
                            state_next = ST_RESP;
                        end else begin
                            err_next   = ERR_OK;
                            tmr_load   = 1'b1;
                            tmr_val    = STB_LOAD;
                            state_next = ST_PUSH_DRV;
                        end
                    end else begin
                        if (occ_zero || stk_empty) begin
                            err_next   = ERR_EMPTY;
                            state_next = ST_RESP;
                        end else begin
                            err_next   = ERR_OK;
                            tmr_load   = 1'b1;
                            tmr_val    = STB_LOAD;
                            state_next = ST_POP_STB;
                        end
                    end
                end
            end

            ST_PUSH_DRV: begin
                stk_push = 1'b1;
                stk_doe  = 1'b1;
                tmr_en   = 1'b1;
                if (tmr_expire) begin
                    tmr_load   = 1'b1;
                    tmr_val    = TMO_LOAD;
                    state_next = ST_PUSH_WAIT;
                end
            end

            ST_PUSH_WAIT: begin
                stk_doe = 1'b1;
                tmr_en  = 1'b1;
                if (stk_done) begin
                    occ_inc    = 1'b1;
                    state_next = ST_RESP;
                end else if (tmr_expire) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = ST_RESP;
                end
            end

            ST_POP_STB: begin
                stk_pop = 1'b1;
                tmr_en  = 1'b1;
                if (tmr_expire) begin
                    tmr_load   = 1'b1;
                    tmr_val    = TMO_LOAD;
                    state_next = ST_POP_WAIT;
                end
            end

            ST_POP_WAIT: begin
                tmr_en = 1'b1;
                if (stk_done) begin
                    capture    = 1'b1;
                    occ_dec    = 1'b1;
                    state_next = ST_RESP;
                end else if (tmr_expire) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = ST_RESP;
                end
            end

            ST_RESP: begin
                rsp_valid  = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= ERR_OK;
            push_data_q <= 8'd0;
            rsp_data_q  <= 8'd0;
            occ_q       <= 8'd0;
            desync_q    <= 1'b0;
        end else begin
            err_q <= err_next;
            if (accept) begin
                push_data_q <= cmd_data;
                rsp_data_q  <= 8'd0;
            end
            if (capture) begin
                rsp_data_q <= stk_din;
            end
            if (occ_inc && !occ_full) begin
                occ_q <= occ_q + 8'd1;
            end else if (occ_dec && !occ_zero) begin
                occ_q <= occ_q - 8'd1;
            end
            if ((state == ST_IDLE) &&
                ((occ_zero != stk_empty) || (occ_full != stk_full))) begin
                desync_q <= 1'b1;
            end
        end
    end

    // Bus and response fields are forced to zero outside their owning states
    // so nothing stale is presented to the device or the core.
    assign stk_dout  = stk_doe ? push_data_q : 8'd0;
    assign rsp_data  = rsp_valid ? rsp_data_q : 8'd0;
    assign rsp_err   = rsp_valid ? err_q : ERR_OK;
    assign occupancy = occ_q;
    assign desync    = desync_q;

endmodule

// File: tb/tb_stack_host_ctrl.sv
// Self-checking bench for stack_host_ctrl: a behavioural stack device on the
// pins, a queue-based reference of the expected stack contents, directed
// scenarios followed by randomized command traffic.
module tb_stack_host_ctrl;

    localparam int DEPTH       = 128;
    localparam int STROBE_CYC  = 2;
    localparam int TIMEOUT_CYC = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_pop = 1'b0;
    logic [7:0] cmd_data = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_dout;
    logic       stk_doe;
    logic [7:0] stk_din = 8'd0;
    logic       stk_done = 1'b1;
    logic       stk_empty = 1'b1;
    logic       stk_full = 1'b0;
    logic [7:0] occupancy;
    logic       desync;

    int n_cmp = 0;
    int n_bad = 0;

    stack_host_ctrl #(
        .DEPTH       (DEPTH),
        .STROBE_CYC  (STROBE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_pop   (cmd_pop),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_dout  (stk_dout),
        .stk_doe   (stk_doe),
        .stk_din   (stk_din),
        .stk_done  (stk_done),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .occupancy (occupancy),
        .desync    (desync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural stack device ----------------
    logic [7:0] dev_q[$];
    int  dev_delay = 0;
    bit  dev_hang  = 1'b0;
    bit  force_ne  = 1'b0;
    bit  busy      = 1'b0;
    bit  op_pop    = 1'b0;
    logic [7:0] op_data = 8'd0;
    int  scnt = 0;
    int  cnt  = 0;

    task automatic dev_complete();
        if (op_pop) begin
            if (dev_q.size() > 0) stk_din <= dev_q.pop_back();
        end else begin
            dev_q.push_back(op_data);
        end
        busy = 1'b0;
        stk_done <= 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            dev_q.delete();
            busy = 1'b0;
            scnt = 0;
            stk_done <= 1'b1;
            stk_din  <= 8'd0;
        end else if (stk_push || stk_pop) begin
            if (scnt == 0) begin
                busy    = 1'b1;
                op_pop  = stk_pop;
                op_data = stk_dout;
                stk_done <= 1'b0;
            end
            scnt++;
            if (scnt == STROBE_CYC) begin
                cnt = dev_delay;
                if (!dev_hang && cnt == 0) dev_complete();
            end
        end else begin
            scnt = 0;
            if (busy) begin
                if (dev_hang) begin
                    if (rsp_valid) begin
                        busy = 1'b0;
                        stk_done <= 1'b1;
                    end
                end else begin
                    cnt--;
                    if (cnt <= 0) dev_complete();
                end
            end
        end
        stk_empty <= (dev_q.size() == 0) && !force_ne;
        stk_full  <= (dev_q.size() == DEPTH);
    end

    // ---------------- pin monitor ----------------
    logic [7:0] exp_dout = 8'd0;
    int  strobe_events = 0;
    int  plen = 0;
    int  qlen = 0;
    bit  prev_push = 1'b0;
    bit  prev_pop  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (stk_push || stk_pop) chk("bus_excl", {31'd0, stk_push & stk_pop}, 32'd0);
            if (stk_push) begin
                chk("push_dout", {24'd0, stk_dout}, {24'd0, exp_dout});
                chk("push_doe", {31'd0, stk_doe}, 32'd1);
            end
            if (stk_pop) chk("pop_doe", {31'd0, stk_doe}, 32'd0);
            if ((stk_push && !prev_push) || (stk_pop && !prev_pop)) strobe_events++;
            if (stk_push) plen++;
            else if (plen > 0) begin
                chk("push_len", plen, STROBE_CYC);
                plen = 0;
            end
            if (stk_pop) qlen++;
            else if (qlen > 0) begin
                chk("pop_len", qlen, STROBE_CYC);
                qlen = 0;
            end
        end
        prev_push = stk_push;
        prev_pop  = stk_pop;
    end

    // ---------------- reference model + command driver ----------------
    logic [7:0] ref_q[$];

    task automatic do_cmd(input bit pop, input logic [7:0] data, input int delay,
                          input bit hang, input bit extra);
        int         exp_lat;
        logic [1:0] exp_err;
        logic [7:0] exp_data;
        int         exp_strobes;
        int         lat;
        int         ev0;
        exp_data = 8'd0;
        exp_strobes = 1;
        if (pop && ref_q.size() == 0) begin
            exp_err = 2'd2; exp_lat = 1; exp_strobes = 0;
        end else if (!pop && ref_q.size() == DEPTH) begin
            exp_err = 2'd1; exp_lat = 1; exp_strobes = 0;
        end else if (hang) begin
            exp_err = 2'd3; exp_lat = STROBE_CYC + TIMEOUT_CYC + 2;
        end else begin
            exp_err = 2'd0; exp_lat = STROBE_CYC + delay + 2;
            if (pop) exp_data = ref_q.pop_back();
            else     ref_q.push_back(data);
        end
        dev_delay = delay;
        dev_hang  = hang;
        exp_dout  = data;
        ev0 = strobe_events;
        cmd_valid = 1'b1;
        cmd_pop   = pop;
        cmd_data  = data;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!extra) cmd_valid = 1'b0;
            else        cmd_data  = ~data;
        end while (!rsp_valid && lat < 200);
        cmd_valid = 1'b0;
        chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        chk("latency", lat, exp_lat);
        chk("rsp_err", {30'd0, rsp_err}, {30'd0, exp_err});
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_data});
        chk("occupancy", {24'd0, occupancy}, ref_q.size());
        chk("ready_in_resp", {31'd0, cmd_ready}, 32'd0);
        chk("doe_in_resp", {31'd0, stk_doe}, 32'd0);
        chk("strobes", strobe_events - ev0, exp_strobes);
        chk("desync_clean", {31'd0, desync}, 32'd0);
        @(negedge clk);
        chk("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        chk("ready_back", {31'd0, cmd_ready}, 32'd1);
        dev_hang = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_q.delete();
    endtask

    initial begin
        int quiet;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_outs", {29'd0, rsp_valid, stk_push, stk_pop}, 32'd0);
        chk("rst_bus", {21'd0, stk_doe, stk_dout, rsp_data[1:0]}, 32'd0);
        chk("rst_misc", {21'd0, rsp_err, occupancy, desync}, 32'd0);
        @(negedge clk);

        // pop from an empty stack is rejected without a strobe
        do_cmd(1'b1, 8'h00, 0, 1'b0, 1'b0);
        // push with done three cycles after the strobe
        do_cmd(1'b0, 8'hA5, 3, 1'b0, 1'b0);
        do_cmd(1'b1, 8'h00, 1, 1'b0, 1'b0);
        // LIFO order
        do_cmd(1'b0, 8'h11, 2, 1'b0, 1'b0);
        do_cmd(1'b0, 8'h22, 0, 1'b0, 1'b0);
        do_cmd(1'b1, 8'h00, 4, 1'b0, 1'b0);
        do_cmd(1'b1, 8'h00, 0, 1'b0, 1'b0);
        // push that never completes times out
        do_cmd(1'b0, 8'h5C, 0, 1'b1, 1'b0);
        // pop that never completes times out
        do_cmd(1'b0, 8'h3E, 1, 1'b0, 1'b0);
        do_cmd(1'b1, 8'h00, 0, 1'b1, 1'b0);
        do_cmd(1'b1, 8'h00, 0, 1'b0, 1'b1);

        // reset in the middle of a push wait
        do_cmd(1'b0, 8'h77, 0, 1'b0, 1'b0);
        dev_hang = 1'b1;
        exp_dout = 8'h99;
        cmd_valid = 1'b1; cmd_pop = 1'b0; cmd_data = 8'h99;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_in_wait", {30'd0, stk_doe, stk_push}, 32'd2);
        pulse_reset();
        dev_hang = 1'b0;
        chk("mid_strobes", {29'd0, stk_push, stk_pop, stk_doe}, 32'd0);
        chk("mid_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_occ", {24'd0, occupancy}, 32'd0);
        quiet = 0;
        repeat (6) begin
            if (rsp_valid) quiet++;
            @(negedge clk);
        end
        chk("mid_no_rsp", quiet, 0);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            do_cmd($urandom_range(9) < 4, 8'($urandom_range(255)), $urandom_range(6),
                   $urandom_range(24) == 0, $urandom_range(3) == 0);
        end

        // fill to capacity, overflow, then drain and underflow
        while (ref_q.size() < DEPTH) do_cmd(1'b0, 8'($urandom_range(255)), 0, 1'b0, 1'b0);
        do_cmd(1'b0, 8'hEE, 0, 1'b0, 1'b0);
        while (ref_q.size() > 0) do_cmd(1'b1, 8'h00, $urandom_range(1), 1'b0, 1'b0);
        do_cmd(1'b1, 8'h00, 0, 1'b0, 1'b0);

        // device flag disagrees with shadow count while idle
        force_ne = 1'b1;
        repeat (3) @(negedge clk);
        chk("desync_set", {31'd0, desync}, 32'd1);
        force_ne = 1'b0;
        repeat (3) @(negedge clk);
        chk("desync_sticky", {31'd0, desync}, 32'd1);
        pulse_reset();
        chk("desync_clear", {31'd0, desync}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
